// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and sizing helpers for the serial bitstream source.
package ser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} ser_state_t;
  localparam int SER_MAX_WIDTH = 32;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/ser_bitstream_src.sv
// ser_bitstream_src: valid/ready word in, gapless serial bitstream out to the sequence detector.
// Define SER_PARITY_EN to append an even-parity bit cycle after each word.
module ser_bitstream_src
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  ser_state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n, rev, ld;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic par, par_n, x_n, x_valid_n, busy_n, word_done_n, acc, last;
  assign rev = {<<{in_data}};
  // the shifter always drains from the top, so LSB-first words are loaded reversed
  assign ld = MSB_FIRST ? in_data : rev;
  assign last = (state == SHIFT) && (bit_cnt == LAST);
`ifdef SER_PARITY_EN
  assign in_ready = (state == IDLE) || (state == PARITY);
`else
  assign in_ready = (state == IDLE) || last;
`endif
  assign acc = in_valid & in_ready;
  always_comb begin
    state_n     = state;
    sh_n        = sh;
    bit_cnt_n   = bit_cnt;
    par_n       = par;
    x_n         = 1'b0;
    x_valid_n   = 1'b0;
    busy_n      = 1'b0;
    word_done_n = 1'b0;
    if (acc) begin
      state_n   = SHIFT;
      sh_n      = ld << 1;
      bit_cnt_n = '0;
      par_n     = ^in_data;
      x_n       = ld[WIDTH-1];
      x_valid_n = 1'b1;
      busy_n    = 1'b1;
    end else if (state == SHIFT && !last) begin
      sh_n        = sh << 1;
      bit_cnt_n   = bit_cnt + 1'b1;
      x_n         = sh[WIDTH-1];
      x_valid_n   = 1'b1;
      busy_n      = 1'b1;
      word_done_n = !PAR && (bit_cnt_n == LAST);
    end else if (PAR && last) begin
      state_n     = PARITY;
      x_n         = par;
      x_valid_n   = 1'b1;
      busy_n      = 1'b1;
      word_done_n = 1'b1;
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sh        <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      bit_cnt   <= bit_cnt_n;
      par       <= par_n;
      x         <= x_n;
      x_valid   <= x_valid_n;
      busy      <= busy_n;
      word_done <= word_done_n;
    end
  end
endmodule

// File: tb/tb_ser_bitstream_src.sv
// tb_ser_bitstream_src: directed checks of an MSB-first and an LSB-first instance sharing one stimulus.
module tb_ser_bitstream_src;
  localparam int W = 5;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L = W + PB;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy0, x0, xv0, busy0, wd0, rdy1, x1, xv1, busy1, wd1;
  int n_cmp = 0, n_err = 0;
  bit q[$];
  bit r[$];
  always #5 clk = ~clk;
  ser_bitstream_src #(.WIDTH(W), .MSB_FIRST(1)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .x(x0), .x_valid(xv0), .busy(busy0), .word_done(wd0)
  );
  ser_bitstream_src #(.WIDTH(W), .MSB_FIRST(0)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .x(x1), .x_valid(xv1), .busy(busy1), .word_done(wd1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [W-1:0] w);
    for (int k = W - 1; k >= 0; k--) q.push_back(w[k]);
    for (int k = 0; k < W; k++) r.push_back(w[k]);
    if (PB != 0) begin
      q.push_back(^w);
      r.push_back(^w);
    end
  endtask
  task automatic bit_at(input string tag, input int i);
    chk({tag, "_x"}, 32'(x0), 32'(q[i]));
    chk({tag, "_x_lsb"}, 32'(x1), 32'(r[i]));
    chk({tag, "_xv"}, 32'(xv0), 32'd1);
    chk({tag, "_busy"}, 32'(busy0), 32'd1);
    chk({tag, "_wd"}, 32'(wd0), 32'((i % L) == L - 1));
    chk({tag, "_rdy"}, 32'(rdy0), 32'((i % L) == L - 1));
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_x"}, 32'(x0), 32'd0);
    chk({tag, "_xv"}, 32'(xv0), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_wd"}, 32'(wd0), 32'd0);
    chk({tag, "_rdy"}, 32'(rdy0), 32'd1);
    chk({tag, "_xv_lsb"}, 32'(xv1), 32'd0);
  endtask
  initial begin
    @(negedge clk);
    idle_chk("rst");
    reset = 1'b1;
    @(negedge clk);
    // single word: 10011 -> 1,0,0,1,1 (LSB-first: 1,1,0,0,1)
    q.delete(); r.delete(); push(5'b10011);
    in_valid = 1'b1; in_data = 5'b10011;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      bit_at("word", i);
      @(negedge clk);
    end
    idle_chk("word_end");
    // back-to-back words with in_valid held
    q.delete(); r.delete(); push(5'b10011); push(5'b10101);
    in_valid = 1'b1; in_data = 5'b10011;
    @(negedge clk); in_data = 5'b10101;
    for (int i = 0; i < 2 * L; i++) begin
      bit_at("b2b", i);
      if (i == L) in_valid = 1'b0;
      @(negedge clk);
    end
    idle_chk("b2b_end");
    // request while busy is ignored; the word present at in_ready is taken
    q.delete(); r.delete(); push(5'b10011); push(5'b01100);
    in_valid = 1'b1; in_data = 5'b10011;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 2 * L; i++) begin
      bit_at("ign", i);
      if (i == 1) begin in_valid = 1'b1; in_data = 5'b11111; end
      if (i == L - 1) in_data = 5'b01100;
      if (i == L) in_valid = 1'b0;
      @(negedge clk);
    end
    idle_chk("ign_end");
    // asynchronous reset during the third bit
    q.delete(); r.delete(); push(5'b10011);
    in_valid = 1'b1; in_data = 5'b10011;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_at("mid", i);
      if (i < 2) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    idle_chk("mid_rst");
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_chk("post_rst");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
